bank_wr_arb: RTL and testbench

BANK_WR_ARB -- requirements
Module: bank_wr_arb

---
 rtl/bank_wr_arb_pkg.sv | 20 ++
 rtl/bank_wr_arb_rr_pick.sv | 33 +++
 rtl/bank_wr_arb.sv | 145 ++++++++++++++
 tb/tb_bank_wr_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_wr_arb_pkg.sv
// Shared types and defaults for the bank write arbiter.
package bank_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_DW    = 2;
  localparam int DEF_DEPTH = 4;
  localparam int CNT_W     = 8;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bank_wr_arb_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk the requests starting at ptr and stop at the first hit.
  always_comb begin
    int          j;
    logic [N-1:0] req_sh;
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    req_sh = '0;
    for (int i = 0; i < N; i++) begin
      j      = (int'(ptr) + i) % N;
      req_sh = req >> j;
      if (!any && req_sh[0]) begin
        any = 1'b1;
        gnt = N'(1) << j;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bank_wr_arb.sv
// Shared bank write port with round-robin arbitration over NREQ requesters.
// Each accepted write costs a GRANT cycle and a WRITE cycle.
// Optional feature: define ARB_LOCK_EN to let a grantee hold priority via req_lock.
module bank_wr_arb
  import bank_wr_arb_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int DW    = DEF_DW,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = idx_w(DEPTH),
  localparam int IW    = idx_w(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0][AW-1:0] req_addr,
  input  logic [NREQ-1:0][DW-1:0] req_data,
  input  logic [NREQ-1:0]         req_lock,
  output logic [NREQ-1:0]         req_ready,
  output logic [DW-1:0]           bank_q [DEPTH-1:0],
  output logic                    grant_vld,
  output logic [IW-1:0]           grant_id,
  output logic [CNT_W-1:0]        wr_cnt
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  state_e          state;
  wr_req_t         wq;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   nxt_ptr;
  logic [IW-1:0]   pick_ptr;
  logic [NREQ-1:0] pk_gnt;
  logic [IW-1:0]   pk_idx;
  logic            pk_any;
  logic            hs;
  logic            hold;

  // Ready is only ever set on the grantee, so any overlap is the handshake.
  assign hs = |(req_valid & req_ready);

`ifdef ARB_LOCK_EN
  logic lock_q;

  // Capture the grantee's lock hint together with its write.
  always_ff @(posedge clk) begin
    if (rst)
      lock_q <= 1'b0;
    else if (state == GRANT && hs)
      lock_q <= req_lock[grant_id];
  end

  assign hold = lock_q;
`else
  logic lock_unused;
  assign lock_unused = ^req_lock;
  assign hold        = 1'b0;
`endif

  // Pointer after the write in flight: stay on a locked grantee, else step past it.
  always_comb begin
    nxt_ptr = grant_id + 1'b1;
    if (hold)
      nxt_ptr = grant_id;
    else if (grant_id == IW'(NREQ-1))
      nxt_ptr = '0;
  end

  // WRITE re-arbitrates with the advanced pointer so GRANT can follow directly.
  assign pick_ptr = (state == WRITE) ? nxt_ptr : rr_ptr;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (pick_ptr),
    .gnt (pk_gnt),
    .idx (pk_idx),
    .any (pk_any)
  );

  // Arbitration FSM with registered ready/grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      req_ready <= '0;
      grant_vld <= 1'b0;
      grant_id  <= '0;
      wr_cnt    <= '0;
      wq        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pk_any) begin
            state     <= GRANT;
            grant_vld <= 1'b1;
            grant_id  <= pk_idx;
            req_ready <= pk_gnt;
          end
        end
        GRANT: begin
          req_ready <= '0;
          if (hs) begin
            state   <= WRITE;
            wq.addr <= req_addr[grant_id];
            wq.data <= req_data[grant_id];
          end else begin
            state     <= IDLE;
            grant_vld <= 1'b0;
          end
        end
        WRITE: begin
          wr_cnt <= wr_cnt + 1'b1;
          rr_ptr <= nxt_ptr;
          if (pk_any) begin
            state     <= GRANT;
            grant_id  <= pk_idx;
            req_ready <= pk_gnt;
          end else begin
            state     <= IDLE;
            grant_vld <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= '0;
          grant_vld <= 1'b0;
        end
      endcase
    end
  end

  // Bank entries: one register per entry, written during WRITE.
  for (genvar e = 0; e < DEPTH; e++) begin : g_bank
    always_ff @(posedge clk) begin
      if (rst)
        bank_q[e] <= '0;
      else if (state == WRITE && wq.addr == AW'(e))
        bank_q[e] <= wq.data;
    end
  end

endmodule

// File: tb/tb_bank_wr_arb.sv
// Bench for bank_wr_arb: directed sequences plus a write scoreboard.
module tb_bank_wr_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int IW    = 2;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic [NREQ-1:0]         req_lock;
  logic [NREQ-1:0]         req_ready;
  logic [DW-1:0]           bank_q [DEPTH-1:0];
  logic                    grant_vld;
  logic [IW-1:0]           grant_id;
  logic [7:0]              wr_cnt;

  bank_wr_arb #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .bank_q    (bank_q),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .wr_cnt    (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_cnt = 0;
  int hs_cnt  = 0;

  typedef struct packed {
    logic [31:0]   due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sbq[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_rst_state(input string t);
    chk({t, "_ready"}, 32'(req_ready), 0);
    chk({t, "_gvld"},  32'(grant_vld), 0);
    chk({t, "_gid"},   32'(grant_id),  0);
    chk({t, "_cnt"},   32'(wr_cnt),    0);
    for (int e = 0; e < DEPTH; e++) chk({t, "_bank"}, 32'(bank_q[e]), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push at handshake, check bank/count two cycles later.
  always @(negedge clk) begin
    sb_t it;
    if (rst) begin
      sbq.delete();
      exp_cnt = 0;
    end else begin
      while (sbq.size() > 0 && int'(sbq[0].due) == cyc) begin
        it      = sbq.pop_front();
        exp_cnt = (exp_cnt + 1) % 256;
        chk("sb_bank", 32'(bank_q[it.addr]), 32'(it.data));
        chk("sb_cnt",  32'(wr_cnt), exp_cnt);
      end
      if (req_ready != '0) chk("ready_onehot", $countones(req_ready), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          it.due  = 32'(cyc + 2);
          it.addr = req_addr[i];
          it.data = req_data[i];
          sbq.push_back(it);
          hs_cnt++;
        end
      end
    end
  end

  initial begin
    int exp_g[5];
    int exp_l[4];
    int base;

    // Single write: ready in cycle 1, bank visible in cycle 3.
    do_reset();
    req_valid   = 4'b0001;
    req_addr[0] = 2'd2;
    req_data[0] = 2'b10;
    smp();
    chk_rst_state("rst0");
    step();  smp();
    chk("w1_ready", 32'(req_ready), 1);
    chk("w1_gvld",  32'(grant_vld), 1);
    chk("w1_gid",   32'(grant_id),  0);
    step();
    req_valid   = '0;
    req_data[0] = 2'b01;
    req_addr[0] = 2'd3;
    smp();
    chk("w1_ready_wr", 32'(req_ready), 0);
    chk("w1_gvld_wr",  32'(grant_vld), 1);
    chk("w1_early",    32'(bank_q[2]), 0);
    step();  smp();
    chk("w1_bank",  32'(bank_q[2]), 2);
    chk("w1_other", 32'(bank_q[3]), 0);
    chk("w1_cnt",   32'(wr_cnt),    1);
    chk("w1_idle",  32'(grant_vld), 0);

    // All requesters valid: rotation 0,1,2,3,0, shared addresses resolve in order.
    do_reset();
    req_addr[0] = 2'd0; req_data[0] = 2'd1;
    req_addr[1] = 2'd1; req_data[1] = 2'd2;
    req_addr[2] = 2'd0; req_data[2] = 2'd3;
    req_addr[3] = 2'd3; req_data[3] = 2'd1;
    req_valid = 4'b1111;
    smp();
    chk_rst_state("rst1");
    exp_g = '{0, 1, 2, 3, 0};
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 10) req_valid = '0;
      smp();
      if (c % 2 == 1) begin
        chk("rr_gid",   32'(grant_id),  exp_g[(c-1)/2]);
        chk("rr_ready", 32'(req_ready), 1 << exp_g[(c-1)/2]);
      end else begin
        chk("rr_ready_wr", 32'(req_ready), 0);
      end
    end
    step();  smp();
    chk("rr_cnt",  32'(wr_cnt),    5);
    chk("rr_b0",   32'(bank_q[0]), 1);
    chk("rr_idle", 32'(grant_vld), 0);

    // Grantee drops valid in GRANT: no write, pointer held.
    do_reset();
    smp();
    chk_rst_state("rst2");
    req_valid = 4'b0001;
    step();  smp();
    step();  smp();
    chk("dr_g0", 32'(grant_id), 0);
    step();  req_valid = '0;
    step();  req_valid = 4'b0010;
    smp();
    chk("dr_idle0", 32'(grant_vld), 0);
    step();  req_valid = '0;
    smp();
    chk("dr_ready1", 32'(req_ready), 2);
    step();  smp();
    chk("dr_idle1",   32'(grant_vld), 0);
    chk("dr_nowrite", 32'(wr_cnt),    1);
    req_valid = 4'b1010;
    step();  smp();
    chk("dr_regrant", 32'(grant_id), 1);
    step();  req_valid = '0;
    step();  smp();
    chk("dr_cnt", 32'(wr_cnt), 2);

    // Lock hint on requester 2 competing with requester 3.
    do_reset();
    req_addr[2] = 2'd1; req_data[2] = 2'd2;
    req_addr[3] = 2'd2; req_data[3] = 2'd3;
    req_valid = 4'b1100;
    req_lock  = 4'b0100;
`ifdef ARB_LOCK_EN
    exp_l = '{2, 2, 2, 3};
`else
    exp_l = '{2, 3, 2, 3};
`endif
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 5) req_lock  = '0;
      if (c == 8) req_valid = '0;
      smp();
      if (c % 2 == 1) chk("lk_gid", 32'(grant_id), exp_l[(c-1)/2]);
    end
    step();  step();  smp();
    chk("lk_cnt", 32'(wr_cnt), 4);

    // Reset in the middle of a WRITE aborts it.
    do_reset();
    req_valid   = 4'b0001;
    req_addr[0] = 2'd0;
    req_data[0] = 2'b11;
    step();
    step();
    req_valid = '0;
    rst       = 1'b1;
    smp();
    step();
    rst = 1'b0;
    smp();
    chk_rst_state("rstwr");
    step();  smp();
    chk("rstwr_hold", 32'(bank_q[0]), 0);

    // 256 back-to-back writes wrap the counter; data churns after each accept.
    do_reset();
    req_valid = 4'b0100;
    base = hs_cnt;
    for (int c = 0; c < 1200; c++) begin
      step();
      req_addr[2] = AW'($urandom_range(0, DEPTH-1));
      req_data[2] = DW'($urandom_range(0, 3));
      smp();
      if (hs_cnt - base >= 256) break;
    end
    chk("wrap_hs", hs_cnt - base, 256);
    step();
    req_valid = '0;
    step();  step();  step();  smp();
    chk("wrap_cnt", 32'(wr_cnt), 0);
    chk("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
